// File: rtl/fnd_scan_arbiter.sv
// fnd_scan_arbiter: two-requester arbiter for a 4-digit multiplexed 7-segment display.
// A granted 14-bit value is clamped to 9999, converted to BCD by a 14-cycle
// shift-add-3 pass, then scanned digit by digit.
// Optional feature: define FND_LZB_EN for leading-zero blanking.
module fnd_scan_arbiter #(
  parameter int SLOT_CYC  = 100_000,
  parameter int BLANK_CYC = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [13:0] val_a,
  input  logic        req_b,
  input  logic [13:0] val_b,
  output logic [1:0]  grant,
  output logic [3:0]  fnd_com,
  output logic [3:0]  fnd_bcd,
  output logic        frame_done
);

  localparam int            CW         = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t        r_state;
  logic [1:0]    r_grant;
  logic          r_rr;        // 0: A wins a tie, 1: B wins a tie
  logic [13:0]   r_bin;
  logic [15:0]   r_bcd;
  logic [3:0]    r_load_cnt;
  logic [1:0]    r_slot;
  logic [CW-1:0] r_cyc;
  logic [3:0]    r_com;
  logic [3:0]    r_dig;
  logic          r_done;

  logic [1:0]    w_arb;
  logic [13:0]   w_sel;
  logic [13:0]   w_snap;
  logic [15:0]   w_dd;
  logic          w_slot_end;
  logic          w_frame_end;
  logic [1:0]    w_nxt_slot;
  logic [CW-1:0] w_nxt_cyc;
  logic [3:0]    w_show;

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next binary bit.
  function automatic logic [15:0] f_dd_step(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] adj;
    adj = 16'd0;
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? (bcd[4*i +: 4] + 4'd3) : bcd[4*i +: 4];
    end
    return {adj[14:0], bit_in};
  endfunction

  // Digit enables for a SCAN cycle: the BLANK sub-phase (and blanked digits) keep all off.
  function automatic logic [3:0] f_com(input logic [1:0] slot, input logic [CW-1:0] cyc,
                                       input logic shown);
    if ((cyc < BLANK_LAST) || !shown) begin
      return 4'b1111;
    end else begin
      return ~(4'b0001 << slot);
    end
  endfunction

  // BCD nibble belonging to a digit slot.
  function automatic logic [3:0] f_digit(input logic [1:0] slot, input logic [15:0] bcd);
    return bcd[{slot, 2'b00} +: 4];
  endfunction

  // Arbitration: lone requester wins, a tie goes to whoever was not granted last.
  always_comb begin
    w_arb = 2'b00;
    if (req_a && req_b) begin
      w_arb = r_rr ? 2'b10 : 2'b01;
    end else if (req_a) begin
      w_arb = 2'b01;
    end else if (req_b) begin
      w_arb = 2'b10;
    end else begin
      w_arb = 2'b00;
    end
  end

  assign w_sel  = w_arb[1] ? val_b : val_a;
  assign w_snap = (w_sel > 14'd9999) ? 14'd9999 : w_sel;
  assign w_dd   = f_dd_step(r_bcd, r_bin[13]);

  // Slot/cycle advance; the slot index only increments inside a frame, so it never wraps past digit 3.
  always_comb begin
    w_slot_end  = (r_cyc == SLOT_LAST);
    w_frame_end = w_slot_end && (r_slot == 2'd3);
    if (w_slot_end) begin
      w_nxt_cyc  = {CW{1'b0}};
      w_nxt_slot = r_slot + 2'd1;
    end else begin
      w_nxt_cyc  = r_cyc + CW'(1);
      w_nxt_slot = r_slot;
    end
  end

`ifdef FND_LZB_EN
  // A digit is lit only if it or a higher digit is nonzero; digit 0 is always lit.
  always_comb begin
    w_show[0] = 1'b1;
    w_show[1] = |r_bcd[15:4];
    w_show[2] = |r_bcd[15:8];
    w_show[3] = |r_bcd[15:12];
  end
`else
  assign w_show = 4'b1111;
`endif

  // Main FSM: IDLE -> LOAD (BCD conversion) -> SCAN (4 slots); outputs registered for the coming cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_grant    <= 2'b00;
      r_rr       <= 1'b0;
      r_bin      <= 14'd0;
      r_bcd      <= 16'd0;
      r_load_cnt <= 4'd0;
      r_slot     <= 2'd0;
      r_cyc      <= {CW{1'b0}};
      r_com      <= 4'b1111;
      r_dig      <= 4'h0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_com  <= 4'b1111;
          r_dig  <= 4'h0;
          r_done <= 1'b0;
          if (w_arb != 2'b00) begin
            r_state    <= ST_LOAD;
            r_grant    <= w_arb;
            r_rr       <= w_arb[0];
            r_bin      <= w_snap;
            r_bcd      <= 16'd0;
            r_load_cnt <= 4'd0;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= 2'b00;
          end
        end
        ST_LOAD: begin
          r_bcd  <= w_dd;
          r_bin  <= {r_bin[12:0], 1'b0};
          r_com  <= 4'b1111;
          r_done <= 1'b0;
          if (r_load_cnt == 4'd13) begin
            r_state <= ST_SCAN;
            r_slot  <= 2'd0;
            r_cyc   <= {CW{1'b0}};
            r_dig   <= w_dd[3:0];
          end else begin
            r_load_cnt <= r_load_cnt + 4'd1;
            r_dig      <= 4'h0;
          end
        end
        ST_SCAN: begin
          if (w_frame_end) begin
            r_com  <= 4'b1111;
            r_dig  <= 4'h0;
            r_done <= 1'b0;
            r_slot <= 2'd0;
            r_cyc  <= {CW{1'b0}};
            if (w_arb != 2'b00) begin
              r_state    <= ST_LOAD;
              r_grant    <= w_arb;
              r_rr       <= w_arb[0];
              r_bin      <= w_snap;
              r_bcd      <= 16'd0;
              r_load_cnt <= 4'd0;
            end else begin
              r_state <= ST_IDLE;
              r_grant <= 2'b00;
            end
          end else begin
            r_slot <= w_nxt_slot;
            r_cyc  <= w_nxt_cyc;
            r_com  <= f_com(w_nxt_slot, w_nxt_cyc, w_show[w_nxt_slot]);
            r_dig  <= f_digit(w_nxt_slot, r_bcd);
            r_done <= (w_nxt_slot == 2'd3) && (w_nxt_cyc == SLOT_LAST);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 2'b00;
          r_com   <= 4'b1111;
          r_dig   <= 4'h0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign grant      = r_grant;
  assign fnd_com    = r_com;
  assign fnd_bcd    = r_dig;
  assign frame_done = r_done;

endmodule

// File: tb/tb_fnd_scan_arbiter.sv
// Directed testbench for fnd_scan_arbiter with SLOT_CYC=10, BLANK_CYC=2.
// Honours FND_LZB_EN when choosing the expected digit enables.
module tb_fnd_scan_arbiter;

  localparam int SLOT  = 10;
  localparam int BLANK = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a;
  logic [13:0] val_a;
  logic        req_b;
  logic [13:0] val_b;
  logic [1:0]  grant;
  logic [3:0]  fnd_com;
  logic [3:0]  fnd_bcd;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FND_LZB_EN
  localparam logic [3:0] SHOW_7 = 4'b0001;
`else
  localparam logic [3:0] SHOW_7 = 4'b1111;
`endif

  fnd_scan_arbiter #(.SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .val_a      (val_a),
    .req_b      (req_b),
    .val_b      (val_b),
    .grant      (grant),
    .fnd_com    (fnd_com),
    .fnd_bcd    (fnd_bcd),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".grant"}, {2'b00, grant}, 4'b0000);
    chk({tag, ".com"}, fnd_com, 4'b1111);
    chk({tag, ".bcd"}, fnd_bcd, 4'h0);
    chk({tag, ".done"}, {3'b000, frame_done}, 4'b0000);
  endtask

  // 14 LOAD cycles: all digits off, bcd 0, no frame_done, grant held.
  task automatic chk_load(input string tag, input logic [1:0] g);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("%s.load%0d.grant", tag, i), {2'b00, grant}, {2'b00, g});
      chk($sformatf("%s.load%0d.com", tag, i), fnd_com, 4'b1111);
      chk($sformatf("%s.load%0d.bcd", tag, i), fnd_bcd, 4'h0);
      chk($sformatf("%s.load%0d.done", tag, i), {3'b000, frame_done}, 4'b0000);
      tick();
    end
  endtask

  // 40 SCAN cycles; requests dropped at cycle 0 of drop_slot when drop_slot >= 0.
  task automatic run_frame(input string tag, input logic [15:0] dig, input logic [1:0] g,
                           input logic [3:0] shown, input int drop_slot);
    logic [3:0] exp_com;
    logic [3:0] on_com;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0:       on_com = 4'b1110;
        1:       on_com = 4'b1101;
        2:       on_com = 4'b1011;
        default: on_com = 4'b0111;
      endcase
      for (int c = 0; c < SLOT; c++) begin
        exp_com = ((c < BLANK) || !shown[s]) ? 4'b1111 : on_com;
        chk($sformatf("%s.s%0dc%0d.grant", tag, s, c), {2'b00, grant}, {2'b00, g});
        chk($sformatf("%s.s%0dc%0d.com", tag, s, c), fnd_com, exp_com);
        chk($sformatf("%s.s%0dc%0d.bcd", tag, s, c), fnd_bcd, dig[4*s +: 4]);
        chk($sformatf("%s.s%0dc%0d.done", tag, s, c), {3'b000, frame_done},
            {3'b000, ((s == 3) && (c == SLOT - 1))});
        if ((s == drop_slot) && (c == 0)) begin
          req_a = 1'b0;
          req_b = 1'b0;
        end
        tick();
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    val_a = 14'd0;
    val_b = 14'd0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("idle");

    // Single requester A, value 1234, two back-to-back 54-cycle frames.
    req_a = 1'b1;
    val_a = 14'd1234;
    tick();
    chk("a1234.grant0", {2'b00, grant}, 4'b0001);
    chk_load("a1234.f1", 2'b01);
    run_frame("a1234.f1", 16'h1234, 2'b01, 4'b1111, -1);
    chk_load("a1234.f2", 2'b01);
    run_frame("a1234.f2", 16'h1234, 2'b01, 4'b1111, -1);

    // Both requesting: frame 3 already granted to A, then B, A, B.
    req_b = 1'b1;
    val_b = 14'd5678;
    chk_load("rr.f3", 2'b01);
    run_frame("rr.f3", 16'h1234, 2'b01, 4'b1111, -1);
    chk_load("rr.f4", 2'b10);
    run_frame("rr.f4", 16'h5678, 2'b10, 4'b1111, -1);
    chk_load("rr.f5", 2'b01);
    run_frame("rr.f5", 16'h1234, 2'b01, 4'b1111, -1);
    chk_load("rr.f6", 2'b10);
    run_frame("rr.f6", 16'h5678, 2'b10, 4'b1111, -1);

    // Reset during LOAD, then B alone with 12000 (clamped); later val_b change ignored.
    rst = 1'b1;
    tick();
    chk_idle("rst_load");
    rst   = 1'b0;
    req_a = 1'b0;
    req_b = 1'b1;
    val_b = 14'd12000;
    tick();
    chk("clamp.grant0", {2'b00, grant}, 4'b0010);
    val_b = 14'd5;
    chk_load("clamp", 2'b10);
    run_frame("clamp", 16'h9999, 2'b10, 4'b1111, -1);

    // A with 4321, request dropped in digit-1 slot; grant persists, then IDLE.
    rst   = 1'b1;
    req_b = 1'b0;
    req_a = 1'b1;
    val_a = 14'd4321;
    tick();
    rst = 1'b0;
    tick();
    chk("drop.grant0", {2'b00, grant}, 4'b0001);
    chk_load("drop", 2'b01);
    run_frame("drop", 16'h4321, 2'b01, 4'b1111, 1);
    chk_idle("drop.idle0");
    tick();
    chk_idle("drop.idle1");

    // Tie after an A frame goes to B; reset mid-SHOW, then A is favoured again.
    req_a = 1'b1;
    req_b = 1'b1;
    val_a = 14'd1111;
    val_b = 14'd2222;
    tick();
    chk("rst_show.grant0", {2'b00, grant}, 4'b0010);
    chk_load("rst_show", 2'b10);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    chk("rst_show.com_pre", fnd_com, 4'b1110);
    chk("rst_show.bcd_pre", fnd_bcd, 4'h2);
    rst = 1'b1;
    tick();
    chk_idle("rst_show");
    rst = 1'b0;
    tick();
    chk("rst_show.grant_new", {2'b00, grant}, 4'b0001);
    chk_load("rst_show.new", 2'b01);
    run_frame("rst_show.new", 16'h1111, 2'b01, 4'b1111, -1);

    // Value 7: upper digits blanked only with leading-zero blanking.
    rst   = 1'b1;
    req_b = 1'b0;
    req_a = 1'b1;
    val_a = 14'd7;
    tick();
    rst = 1'b0;
    tick();
    chk("seven.grant0", {2'b00, grant}, 4'b0001);
    chk_load("seven", 2'b01);
    run_frame("seven", 16'h0007, 2'b01, SHOW_7, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fnd_scan_arbiter.md
FND_SCAN_ARBITER -- requirements
Module: fnd_scan_arbiter

Interface
REQ-001 Parameter SLOT_CYC, default 100_000, clk cycles per digit slot (1 kHz digit rate at 100 MHz).
REQ-002 Parameter BLANK_CYC, default 8, leading cycles of each slot with all digits off (anti-ghosting); SHALL satisfy 1 <= BLANK_CYC < SLOT_CYC.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_a  in  1  requester A wants the display (level).
REQ-006 val_a  in  14  requester A binary value.
REQ-007 req_b  in  1  requester B wants the display (level).
REQ-008 val_b  in  14  requester B binary value.
REQ-009 grant  out  2  one-hot owner of current frame (bit0=A, bit1=B), 2'b00 when idle.
REQ-010 fnd_com  out  4  active-low digit enables, bit0=ones ... bit3=thousands.
REQ-011 fnd_bcd  out  4  BCD digit for the currently enabled position, feeds the 7-segment decoder.
REQ-012 frame_done  out  1  one-cycle pulse on the last cycle of digit-3 slot.

Function
REQ-013 FSM states SHALL be IDLE, LOAD, SCAN; SCAN has BLANK and SHOW sub-phases per slot.
REQ-014 IDLE: fnd_com=4'b1111, grant=2'b00; requests sampled every cycle; any request -> arbitrate, register grant, snapshot granted val, enter LOAD next cycle.
REQ-015 Arbitration: single requester wins; both requesting -> round-robin, owner = requester not granted last; rr pointer favours A after reset.
REQ-016 Snapshot SHALL clamp values >9999 to 9999; val_x changes after snapshot are ignored until next frame.
REQ-017 LOAD: sequential shift-add-3 binary-to-BCD over exactly 14 cycles, fnd_com=4'b1111; then SCAN at digit 0.
REQ-018 SCAN: digits 0,1,2,3 in order, each SLOT_CYC cycles; first BLANK_CYC cycles fnd_com=4'b1111, remainder drives the single active-low bit for that digit (1110,1101,1011,0111).
REQ-019 fnd_bcd SHALL equal the snapshot digit of the current slot throughout the slot, 0 outside SCAN.
REQ-020 Grant SHALL persist for the full frame even if the owner deasserts its request mid-frame.
REQ-021 Frame boundary (cycle after frame_done): re-arbitrate per REQ-015 and go to LOAD; no request -> IDLE; frame_done SHALL never pulse outside SCAN.
REQ-022 Slot and cycle counters SHALL restart at 0 on every LOAD-to-SCAN transition; no wrap beyond digit 3.

Reset
REQ-023 rst SHALL, next clock edge, force: state IDLE, grant=2'b00, fnd_com=4'b1111, fnd_bcd=4'h0, frame_done=0, rr pointer=A, counters and snapshot=0.
REQ-024 rst mid-LOAD or mid-SCAN SHALL abort the frame with no frame_done pulse; rst has priority over all other inputs.

Configuration
REQ-025 Macro FND_LZB_EN: defined -> leading-zero blanking: digits above the highest nonzero digit keep fnd_com=4'b1111 for their whole slot (slot timing unchanged, digit 0 always shown, value 0 shows single "0").
REQ-026 FND_LZB_EN undefined -> all four digits displayed, leading zeros included.

Verification (SLOT_CYC=10, BLANK_CYC=2)
REQ-027 req_a=1, val_a=1234, req_b=0 -> grant=01 one cycle after req; 14 LOAD cycles; fnd_bcd 4,3,2,1 with fnd_com 1110/1101/1011/0111 for 8 of every 10 cycles; frame_done every 54 cycles (40 SCAN + 14 LOAD).
REQ-028 req_a=req_b=1 held -> grant sequence 01,10,01,10 on successive frames.
REQ-029 val_b=12000 only requester -> digits 9,9,9,9.
REQ-030 req_a dropped at digit-1 slot -> digits 2,3 still shown, frame_done pulses, then IDLE with fnd_com=1111, grant=00.
REQ-031 rst pulse mid-SHOW -> next cycle all REQ-023 values, no frame_done; new frame restarts with A favoured.
REQ-032 val_a=7: FND_LZB_EN defined -> only digit-0 slot active (1110, bcd 7); undefined -> 0,0,0 shown in upper slots.
